// File: rtl/mux_pkg.sv
// Shared constants and select type for the 8:1 lane multiplexer.
package mux_pkg;

    localparam int unsigned N_LANES = 8;
    localparam int unsigned SEL_W   = 3;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux2_1.sv
// 2:1 multiplexer cell, the building block of the mux_8to1 select tree.
module mux2_1 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux_8to1.sv
// 8:1 lane multiplexer built as a 3-level tree of mux2_1 cells.
// Define MUX_8TO1_OUTREG_EN to register out/out_valid (1-cycle latency, sync reset).
module mux_8to1
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_LANES*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    output logic [WIDTH-1:0]         out,
    output logic                     out_valid
);

    logic [WIDTH-1:0] lvl1 [N_LANES/2];
    logic [WIDTH-1:0] lvl2 [N_LANES/4];
    logic [WIDTH-1:0] tree_out;

    // sel[0] picks within pairs
    for (genvar i = 0; i < N_LANES / 2; i++) begin : g_lvl1
        mux2_1 #(
            .WIDTH(WIDTH)
        ) u_mux (
            .in0(in[(2*i)*WIDTH +: WIDTH]),
            .in1(in[(2*i+1)*WIDTH +: WIDTH]),
            .sel(sel[0]),
            .out(lvl1[i])
        );
    end

    // sel[1] picks within quads
    for (genvar i = 0; i < N_LANES / 4; i++) begin : g_lvl2
        mux2_1 #(
            .WIDTH(WIDTH)
        ) u_mux (
            .in0(lvl1[2*i]),
            .in1(lvl1[2*i+1]),
            .sel(sel[1]),
            .out(lvl2[i])
        );
    end

    // sel[2] picks between halves
    for (genvar i = 0; i < 1; i++) begin : g_lvl3
        mux2_1 #(
            .WIDTH(WIDTH)
        ) u_mux (
            .in0(lvl2[0]),
            .in1(lvl2[1]),
            .sel(sel[2]),
            .out(tree_out)
        );
    end

`ifdef MUX_8TO1_OUTREG_EN
    logic [WIDTH-1:0] out_d, out_q;
    logic             out_valid_d, out_valid_q;

    always_comb begin
        out_d       = tree_out;
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
`else
    logic unused_clk_reset;

    assign unused_clk_reset = clk ^ reset;
    assign out              = tree_out;
    assign out_valid        = in_valid;
`endif

endmodule

// File: tb/tb_mux_8to1.sv
// Self-checking bench for mux_8to1: WIDTH=1 and WIDTH=8 instances, directed plus random stimulus.
module tb_mux_8to1;

    logic        clk;
    logic        reset;
    logic [7:0]  in1;
    logic [63:0] in8;
    logic [2:0]  sel;
    logic        in_valid;
    logic        out1;
    logic        out_valid1;
    logic [7:0]  out8;
    logic        out_valid8;

    int n_checks;
    int n_errors;

    mux_8to1 #(
        .WIDTH(1)
    ) u_dut1 (
        .clk      (clk),
        .reset    (reset),
        .in       (in1),
        .sel      (sel),
        .in_valid (in_valid),
        .out      (out1),
        .out_valid(out_valid1)
    );

    mux_8to1 #(
        .WIDTH(8)
    ) u_dut8 (
        .clk      (clk),
        .reset    (reset),
        .in       (in8),
        .sel      (sel),
        .in_valid (in_valid),
        .out      (out8),
        .out_valid(out_valid8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus and compare both instances to the reference model.
    task automatic step(input string tag, input logic [7:0] i1, input logic [63:0] i8,
                        input logic [2:0] s, input logic v, input logic r);
        logic [63:0] exp1, exp8;
        logic        expv;
        @(negedge clk);
        in1      = i1;
        in8      = i8;
        sel      = s;
        in_valid = v;
        reset    = r;
        exp1 = (64'(i1) >> s) & 64'h1;
        exp8 = (i8 >> (int'(s) * 8)) & 64'hFF;
        expv = v;
`ifdef MUX_8TO1_OUTREG_EN
        if (r) begin
            exp1 = '0;
            exp8 = '0;
            expv = 1'b0;
        end
        @(posedge clk);
        #1;
`else
        #1;
`endif
        check({tag, ".out1"}, 64'(out1), exp1);
        check({tag, ".out8"}, 64'(out8), exp8);
        check({tag, ".valid1"}, 64'(out_valid1), 64'(expv));
        check({tag, ".valid8"}, 64'(out_valid8), 64'(expv));
    endtask

    initial begin
        logic [63:0] lanes8;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        in1      = '0;
        in8      = '0;
        sel      = '0;
        in_valid = 1'b0;

        step("reset", 8'h5A, 64'h0123_4567_89AB_CDEF, 3'd2, 1'b1, 1'b1);

        step("top_lane", 8'h80, 64'h8000_0000_0000_0000, 3'd7, 1'b1, 1'b0);
        step("lane0_of_80", 8'h80, 64'h8000_0000_0000_0000, 3'd0, 1'b1, 1'b0);

        for (int k = 0; k < 8; k++) begin
            step("walk_hit", 8'(1 << k), 64'hFF << (k * 8), 3'(k), 1'b1, 1'b0);
            step("walk_miss", 8'(1 << k), 64'hFF << (k * 8), 3'((k + 1) % 8), 1'b1, 1'b0);
        end

        for (int k = 0; k < 8; k++) lanes8[k*8 +: 8] = 8'(8'h10 + k);
        for (int k = 0; k < 8; k++) step("sweep", 8'hA5, lanes8, 3'(k), 1'b1, 1'b0);

        step("pre_reset", 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3, 1'b1, 1'b0);
        step("mid_reset", 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3, 1'b1, 1'b1);
        step("post_reset", 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3, 1'b0, 1'b0);

        step("comb_hit", 8'h08, 64'h0000_0000_AA00_0000, 3'd3, 1'b1, 1'b0);
        step("comb_miss", 8'h08, 64'h0000_0000_AA00_0000, 3'd2, 1'b0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            step("rand", 8'($urandom), {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
